// File: rtl/gate_response_checker.sv
// gate_response_checker: compares N_DUT AND-gate implementations against a golden AND and tracks coverage
module gate_response_checker #(
   parameter int N_IN  = 2,
   parameter int N_DUT = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             vec_valid_i,
   output logic             vec_ready_o,
   input  logic [N_IN-1:0]  vec_in_i,
   input  logic [N_DUT-1:0] dut_out_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0] vec_cnt_o,
   output logic [N_IN-1:0]  first_fail_vec_o,
   output logic [N_DUT-1:0] first_fail_mask_o
);
   localparam int NV = 2 ** N_IN;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d, vec_cnt_q, vec_cnt_d;
   logic [N_IN-1:0]  ff_vec_q, ff_vec_d;
   logic [N_DUT-1:0] ff_mask_q, ff_mask_d, fail_mask;
   logic [NV-1:0]    cov_q, cov_d, cov_hit;
   logic             accept, mismatch;
   assign fail_mask   = dut_out_i ^ {N_DUT{&vec_in_i}};
   assign mismatch    = |fail_mask;
   assign vec_ready_o = (state_q == RUN) & ~abort_i;
   assign accept      = vec_valid_i & vec_ready_o & ~start_i;
   assign cov_hit     = cov_q | (NV'(1) << vec_in_i);
   assign busy_o            = state_q == RUN;
   assign done_o            = state_q == DONE;
   assign pass_o            = done_o & ~|err_cnt_q & &cov_q;
   assign err_cnt_o         = err_cnt_q;
   assign vec_cnt_o         = vec_cnt_q;
   assign first_fail_vec_o  = ff_vec_q;
   assign first_fail_mask_o = ff_mask_q;
   // next state: start clears the session, abort ends it, accepts update counters and coverage
   always_comb begin
      state_d   = state_q;
      err_cnt_d = err_cnt_q;
      vec_cnt_d = vec_cnt_q;
      ff_vec_d  = ff_vec_q;
      ff_mask_d = ff_mask_q;
      cov_d     = cov_q;
      if (start_i) begin
         state_d   = RUN;
         err_cnt_d = '0;
         vec_cnt_d = '0;
         ff_vec_d  = '0;
         ff_mask_d = '0;
         cov_d     = '0;
      end else if (state_q == RUN && abort_i) begin
         state_d = DONE;
      end else if (accept) begin
         vec_cnt_d = (&vec_cnt_q) ? vec_cnt_q : vec_cnt_q + CNT_W'(1);
         cov_d     = cov_hit;
         state_d   = (&cov_hit) ? DONE : RUN;
         if (mismatch) begin
            err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
            ff_vec_d  = (err_cnt_q == '0) ? vec_in_i : ff_vec_q;
            ff_mask_d = (err_cnt_q == '0) ? fail_mask : ff_mask_q;
         end
      end
   end
   // state and result registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         err_cnt_q <= '0;
         vec_cnt_q <= '0;
         ff_vec_q  <= '0;
         ff_mask_q <= '0;
         cov_q     <= '0;
      end else begin
         state_q   <= state_d;
         err_cnt_q <= err_cnt_d;
         vec_cnt_q <= vec_cnt_d;
         ff_vec_q  <= ff_vec_d;
         ff_mask_q <= ff_mask_d;
         cov_q     <= cov_d;
      end
   end
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: scoreboard bench for gate_response_checker (CNT_W=8 and CNT_W=2 instances)
module tb_gate_response_checker;
   logic       clk = 0, rst_n = 0, start_i = 0, abort_i = 0, vec_valid_i = 0;
   logic [1:0] vec_in_i = 0;
   logic [2:0] dut_out_i = 0;
   logic       vec_ready_o, busy_o, done_o, pass_o;
   logic [7:0] err_cnt_o, vec_cnt_o;
   logic [1:0] ffv_o;
   logic [2:0] ffm_o;
   logic       r2, b2, d2, p2;
   logic [1:0] e2, v2, fv2;
   logic [2:0] fm2;
   typedef logic [27:0] snap_t;
   snap_t      sb[$], ob[$];
   snap_t      e, o;
   int         passed = 0, total = 0;
   int         m_st = 0, m_err = 0, m_vec = 0, m_err2 = 0, m_vec2 = 0;
   logic [3:0] m_cov = 0;
   logic [1:0] m_ffv = 0;
   logic [2:0] m_ffm = 0;
   bit         m_hf = 0;

   gate_response_checker dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .vec_valid_i(vec_valid_i), .vec_ready_o(vec_ready_o), .vec_in_i(vec_in_i),
      .dut_out_i(dut_out_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
      .err_cnt_o(err_cnt_o), .vec_cnt_o(vec_cnt_o),
      .first_fail_vec_o(ffv_o), .first_fail_mask_o(ffm_o));

   gate_response_checker #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .vec_valid_i(vec_valid_i), .vec_ready_o(r2), .vec_in_i(vec_in_i),
      .dut_out_i(dut_out_i), .busy_o(b2), .done_o(d2), .pass_o(p2),
      .err_cnt_o(e2), .vec_cnt_o(v2),
      .first_fail_vec_o(fv2), .first_fail_mask_o(fm2));

   always #5 clk = ~clk;

   function automatic snap_t dut_snap();
      return {busy_o, done_o, pass_o, err_cnt_o, vec_cnt_o, ffv_o, ffm_o, e2, v2};
   endfunction

   function automatic snap_t model_snap();
      return {m_st == 1, m_st == 2, m_st == 2 && m_err == 0 && &m_cov,
              8'(m_err), 8'(m_vec), m_ffv, m_ffm, 2'(m_err2), 2'(m_vec2)};
   endfunction

   function automatic void model_clear();
      m_err = 0; m_vec = 0; m_err2 = 0; m_vec2 = 0;
      m_cov = 0; m_ffv = 0; m_ffm = 0; m_hf = 0;
   endfunction

   task automatic cycle(input logic st, input logic ab, input logic vv,
                        input logic [1:0] v, input logic [2:0] d);
      logic [2:0] mask;
      @(negedge clk);
      start_i = st; abort_i = ab; vec_valid_i = vv; vec_in_i = v; dut_out_i = d;
      if (st) begin
         model_clear();
         m_st = 1;
      end else if (m_st == 1 && ab) begin
         m_st = 2;
      end else if (m_st == 1 && vv) begin
         mask = d ^ {3{&v}};
         if (m_vec < 255) m_vec++;
         if (m_vec2 < 3) m_vec2++;
         m_cov[v] = 1'b1;
         if (mask != 0) begin
            if (!m_hf) begin
               m_hf = 1; m_ffv = v; m_ffm = mask;
            end
            if (m_err < 255) m_err++;
            if (m_err2 < 3) m_err2++;
         end
         if (&m_cov) m_st = 2;
      end
      sb.push_back(model_snap());
      @(posedge clk);
      #1 ob.push_back(dut_snap());
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({busy_o, done_o, pass_o, vec_ready_o, err_cnt_o, vec_cnt_o, ffv_o, ffm_o} !== '0)
         $display("FAIL reset outputs: got=%h want=0",
                  {busy_o, done_o, pass_o, vec_ready_o, err_cnt_o, vec_cnt_o, ffv_o, ffm_o});
      else passed++;
      @(negedge clk) rst_n = 1;
      cycle(0, 0, 1, 2'b11, 3'b111);
      cycle(0, 0, 1, 2'b00, 3'b000);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); total++;
         if (o !== e) $display("FAIL reset_idle sb: got=%h want=%h", o, e); else passed++;
      end
   endtask

   task automatic test_full_pass();
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 1, 2'b00, 3'b000);
      cycle(0, 0, 1, 2'b01, 3'b000);
      cycle(0, 0, 1, 2'b10, 3'b000);
      total++;
      if (done_o !== 1'b0) $display("FAIL full_pass early_done: got=%b want=0", done_o); else passed++;
      cycle(0, 0, 1, 2'b11, 3'b111);
      total++;
      if ({done_o, pass_o, err_cnt_o, vec_cnt_o} !== {1'b1, 1'b1, 8'd0, 8'd4})
         $display("FAIL full_pass result: got done=%b pass=%b err=%0d vec=%0d want 1 1 0 4",
                  done_o, pass_o, err_cnt_o, vec_cnt_o);
      else passed++;
      cycle(0, 0, 0, 0, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); total++;
         if (o !== e) $display("FAIL full_pass sb: got=%h want=%h", o, e); else passed++;
      end
   endtask

   task automatic test_mismatch();
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 1, 2'b00, 3'b000);
      cycle(0, 0, 1, 2'b01, 3'b000);
      cycle(0, 0, 1, 2'b10, 3'b010);
      cycle(0, 0, 1, 2'b11, 3'b111);
      total++;
      if ({done_o, pass_o, err_cnt_o, ffv_o, ffm_o} !== {1'b1, 1'b0, 8'd1, 2'b10, 3'b010})
         $display("FAIL mismatch result: got done=%b pass=%b err=%0d ffv=%b ffm=%b want 1 0 1 10 010",
                  done_o, pass_o, err_cnt_o, ffv_o, ffm_o);
      else passed++;
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); total++;
         if (o !== e) $display("FAIL mismatch sb: got=%h want=%h", o, e); else passed++;
      end
   endtask

   task automatic test_abort_partial();
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 1, 2'b00, 3'b000);
      cycle(0, 0, 1, 2'b00, 3'b000);
      cycle(0, 0, 1, 2'b01, 3'b000);
      cycle(0, 0, 1, 2'b10, 3'b000);
      cycle(0, 1, 0, 0, 0);
      total++;
      if ({done_o, pass_o, err_cnt_o, vec_cnt_o} !== {1'b1, 1'b0, 8'd0, 8'd4})
         $display("FAIL abort_partial result: got done=%b pass=%b err=%0d vec=%0d want 1 0 0 4",
                  done_o, pass_o, err_cnt_o, vec_cnt_o);
      else passed++;
      cycle(0, 0, 0, 0, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); total++;
         if (o !== e) $display("FAIL abort_partial sb: got=%h want=%h", o, e); else passed++;
      end
   endtask

   task automatic test_abort_with_valid();
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 1, 2'b00, 3'b000);
      total++;
      if (vec_ready_o !== 1'b1) $display("FAIL ready_run: got=%b want=1", vec_ready_o); else passed++;
      abort_i = 1;
      #1 total++;
      if (vec_ready_o !== 1'b0) $display("FAIL ready_abort: got=%b want=0", vec_ready_o); else passed++;
      cycle(0, 1, 1, 2'b01, 3'b000);
      total++;
      if ({done_o, vec_cnt_o} !== {1'b1, 8'd1})
         $display("FAIL abort_valid: got done=%b vec=%0d want 1 1", done_o, vec_cnt_o);
      else passed++;
      cycle(1, 0, 0, 0, 0);
      total++;
      if ({busy_o, err_cnt_o, vec_cnt_o} !== {1'b1, 8'd0, 8'd0})
         $display("FAIL restart_done: got busy=%b err=%0d vec=%0d want 1 0 0", busy_o, err_cnt_o, vec_cnt_o);
      else passed++;
      cycle(0, 0, 1, 2'b11, 3'b011);
      cycle(1, 0, 1, 2'b10, 3'b111);
      total++;
      if ({busy_o, err_cnt_o, vec_cnt_o, ffm_o} !== {1'b1, 8'd0, 8'd0, 3'b000})
         $display("FAIL restart_run: got busy=%b err=%0d vec=%0d ffm=%b want 1 0 0 000",
                  busy_o, err_cnt_o, vec_cnt_o, ffm_o);
      else passed++;
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); total++;
         if (o !== e) $display("FAIL abort_valid sb: got=%h want=%h", o, e); else passed++;
      end
   endtask

   task automatic test_async_reset();
      cycle(0, 0, 1, 2'b00, 3'b001);
      cycle(0, 0, 1, 2'b01, 3'b000);
      @(negedge clk);
      #2 rst_n = 0;
      m_st = 0;
      model_clear();
      #1 total++;
      if ({busy_o, done_o, pass_o, vec_ready_o, err_cnt_o, vec_cnt_o, ffv_o, ffm_o} !== '0)
         $display("FAIL async_reset: got=%h want=0",
                  {busy_o, done_o, pass_o, vec_ready_o, err_cnt_o, vec_cnt_o, ffv_o, ffm_o});
      else passed++;
      @(negedge clk) rst_n = 1;
      cycle(0, 0, 1, 2'b11, 3'b111);
      cycle(0, 0, 1, 2'b10, 3'b100);
      total++;
      if ({busy_o, vec_cnt_o} !== {1'b0, 8'd0})
         $display("FAIL idle_ignore: got busy=%b vec=%0d want 0 0", busy_o, vec_cnt_o);
      else passed++;
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); total++;
         if (o !== e) $display("FAIL async_reset sb: got=%h want=%h", o, e); else passed++;
      end
   endtask

   task automatic test_saturation();
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 2'b00, 3'b111);
      total++;
      if ({e2, v2, err_cnt_o, vec_cnt_o, ffv_o, ffm_o} !== {2'd3, 2'd3, 8'd5, 8'd5, 2'b00, 3'b111})
         $display("FAIL saturation: got e2=%0d v2=%0d err=%0d vec=%0d ffv=%b ffm=%b want 3 3 5 5 00 111",
                  e2, v2, err_cnt_o, vec_cnt_o, ffv_o, ffm_o);
      else passed++;
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = ob.pop_front(); total++;
         if (o !== e) $display("FAIL saturation sb: got=%h want=%h", o, e); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_mismatch();
      test_abort_partial();
      test_abort_with_valid();
      test_async_reset();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
